// File: rtl/opc6_io_pkg.sv
// Shared definitions for the OPC6 memory-mapped UART: register map,
// STATUS bit positions and serial engine state encodings.
package opc6_io_pkg;

  localparam logic [1:0] OFS_DATA   = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_CTRL   = 2'd2;
  localparam logic [1:0] OFS_DIV    = 2'd3;

  localparam int ST_RX_AVAIL      = 0;
  localparam int ST_TX_HOLD_EMPTY = 1;
  localparam int ST_TX_BUSY       = 2;
  localparam int ST_RX_OVR        = 3;
  localparam int ST_FRM_ERR       = 4;
  localparam int ST_TX_OVR        = 5;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // A divisor of 0 or 1 cannot produce a start-bit midpoint, so 2 is the floor.
  function automatic logic [15:0] clamp_div(input logic [15:0] value);
    return (value < 16'd2) ? 16'd2 : value;
  endfunction

endpackage

// File: rtl/opc6_uart_rx.sv
// 8N1 receiver: synchronises rxd, validates the start bit at mid-bit and
// emits a one-cycle byte_valid or frm_err pulse after the stop-bit sample.
module opc6_uart_rx
  import opc6_io_pkg::*;
(
  input  logic        clk,
  input  logic        reset_b,
  input  logic        rxd,
  input  logic [15:0] div,
  output logic        byte_valid,
  output logic [7:0]  rx_byte,
  output logic        frm_err
);

  logic        sync1, sync2;
  rx_state_t   state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [15:0] div_l, div_l_nx;
  logic [2:0]  bitn, bitn_nx;
  logic [7:0]  shift, shift_nx;
  logic        valid_nx, err_nx;

  // The line idles high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
    end
  end

  // NOTE: every signal assigned here gets a default first so no latch can be inferred.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    div_l_nx = div_l;
    bitn_nx  = bitn;
    shift_nx = shift;
    valid_nx = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      RX_IDLE: begin
        if (!sync2) begin
          state_nx = RX_START;
          div_l_nx = div;
          cnt_nx   = {1'b0, div[15:1]} - 16'd1;
        end
      end
      RX_START: begin
        if (cnt == 16'd0) begin
          if (sync2) begin
            state_nx = RX_IDLE;
          end else begin
            state_nx = RX_DATA;
            cnt_nx   = div_l - 16'd1;
            bitn_nx  = 3'd0;
          end
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      RX_DATA: begin
        if (cnt == 16'd0) begin
          shift_nx = {sync2, shift[7:1]};
          cnt_nx   = div_l - 16'd1;
          if (bitn == 3'd7) state_nx = RX_STOP;
          else              bitn_nx  = bitn + 3'd1;
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      RX_STOP: begin
        if (cnt == 16'd0) begin
          state_nx = RX_IDLE;
          valid_nx = sync2;
          err_nx   = !sync2;
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end
      default: state_nx = RX_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      div_l      <= '0;
      bitn       <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frm_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      div_l      <= div_l_nx;
      bitn       <= bitn_nx;
      shift      <= shift_nx;
      byte_valid <= valid_nx;
      frm_err    <= err_nx;
    end
  end

  // The shifter is untouched while idle, so the byte is stable during the pulse.
  assign rx_byte = shift;

endmodule

// File: rtl/opc6_uart_io.sv
// OPC6 I/O-space UART: bus decode, register file, 8N1 transmitter,
// receive FIFO and registered active-low interrupt.
module opc6_uart_io
  import opc6_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFE00,
  parameter logic [15:0] DIV_RESET = 16'd434,
  parameter int          RXF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        clken,
  input  logic        vio,
  input  logic        rnw,
  input  logic [15:0] address,
  input  logic [15:0] bus_din,
  output logic [15:0] bus_dout,
  output logic        sel,
  input  logic        rxd,
  output logic        txd,
  output logic        int_b
);

  localparam int PW = $clog2(RXF_DEPTH);

  logic       hit;
  logic [1:0] ofs;
  logic       rd_data, rd_status, wr_data, wr_ctrl, wr_div;

  assign hit       = vio && (address[15:2] == BASE_ADDR[15:2]);
  assign ofs       = address[1:0];
  assign sel       = hit;
  assign rd_data   = hit && rnw  && clken && (ofs == OFS_DATA);
  assign rd_status = hit && rnw  && clken && (ofs == OFS_STATUS);
  assign wr_data   = hit && !rnw && clken && (ofs == OFS_DATA);
  assign wr_ctrl   = hit && !rnw && clken && (ofs == OFS_CTRL);
  assign wr_div    = hit && !rnw && clken && (ofs == OFS_DIV);

  logic        rx_ie, tx_ie;
  logic [15:0] div_reg;
  logic [7:0]  hold;
  logic        hold_full, hold_free;
  logic        tx_ovr, rx_ovr, frm_err;

  logic       rx_valid, rx_ferr;
  logic [7:0] rx_byte;

  opc6_uart_rx u_rx (
    .clk        (clk),
    .reset_b    (reset_b),
    .rxd        (rxd),
    .div        (div_reg),
    .byte_valid (rx_valid),
    .rx_byte    (rx_byte),
    .frm_err    (rx_ferr)
  );

  // Receive FIFO: one extra pointer bit separates full from empty.
  logic [7:0]  rx_mem [RXF_DEPTH];
  logic [PW:0] rd_ptr, wr_ptr;
  logic        rxf_empty, rxf_full, rx_pop, rx_push;
  logic [7:0]  rx_head;

  assign rxf_empty = (rd_ptr == wr_ptr);
  assign rxf_full  = (rd_ptr[PW] != wr_ptr[PW]) && (rd_ptr[PW-1:0] == wr_ptr[PW-1:0]);
  assign rx_head   = rx_mem[rd_ptr[PW-1:0]];
  assign rx_pop    = rd_data && !rxf_empty;
  assign rx_push   = rx_valid && (!rxf_full || rx_pop);

  // NOTE: the FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[wr_ptr[PW-1:0]] <= rx_byte;
  end

  // Transmit engine
  tx_state_t   tx_state, tx_state_nx;
  logic [15:0] tx_cnt, tx_cnt_nx;
  logic [15:0] tx_div, tx_div_nx;
  logic [7:0]  tx_shift, tx_shift_nx;
  logic [2:0]  tx_bitn, tx_bitn_nx;
  logic        txd_nx, tx_load;

  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_div_nx   = tx_div;
    tx_shift_nx = tx_shift;
    tx_bitn_nx  = tx_bitn;
    txd_nx      = txd;
    tx_load     = 1'b0;
    unique case (tx_state)
      TX_IDLE: tx_load = hold_full;
      TX_START: begin
        if (tx_cnt == 16'd0) begin
          tx_state_nx = TX_DATA;
          tx_cnt_nx   = tx_div - 16'd1;
          tx_bitn_nx  = 3'd0;
          txd_nx      = tx_shift[0];
        end else begin
          tx_cnt_nx = tx_cnt - 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt == 16'd0) begin
          tx_cnt_nx = tx_div - 16'd1;
          if (tx_bitn == 3'd7) begin
            tx_state_nx = TX_STOP;
            txd_nx      = 1'b1;
          end else begin
            tx_shift_nx = {1'b0, tx_shift[7:1]};
            tx_bitn_nx  = tx_bitn + 3'd1;
            txd_nx      = tx_shift[1];
          end
        end else begin
          tx_cnt_nx = tx_cnt - 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == 16'd0) begin
          tx_state_nx = TX_IDLE;
          tx_load     = hold_full;
        end else begin
          tx_cnt_nx = tx_cnt - 16'd1;
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase
    // Frame start from idle or straight out of STOP, so queued bytes go out gap-free.
    if (tx_load) begin
      tx_state_nx = TX_START;
      tx_shift_nx = hold;
      tx_div_nx   = div_reg;
      tx_cnt_nx   = div_reg - 16'd1;
      txd_nx      = 1'b0;
    end
  end

  // Holding frees on the same edge the shifter takes it, so a coincident write lands.
  assign hold_free = !hold_full || tx_load;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_div    <= '0;
      tx_shift  <= '0;
      tx_bitn   <= '0;
      txd       <= 1'b1;
      hold      <= '0;
      hold_full <= 1'b0;
      tx_ovr    <= 1'b0;
      rx_ovr    <= 1'b0;
      frm_err   <= 1'b0;
      rx_ie     <= 1'b0;
      tx_ie     <= 1'b0;
      div_reg   <= DIV_RESET;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      int_b     <= 1'b1;
    end else begin
      tx_state  <= tx_state_nx;
      tx_cnt    <= tx_cnt_nx;
      tx_div    <= tx_div_nx;
      tx_shift  <= tx_shift_nx;
      tx_bitn   <= tx_bitn_nx;
      txd       <= txd_nx;
      if (wr_data && hold_free) hold <= bus_din[7:0];
      hold_full <= (hold_full && !tx_load) || (wr_data && hold_free);
      // Sticky bits: a new event on the same edge as a STATUS read wins.
      tx_ovr    <= (wr_data && !hold_free) || (tx_ovr && !rd_status);
      rx_ovr    <= (rx_valid && !rx_push) || (rx_ovr && !rd_status);
      frm_err   <= rx_ferr || (frm_err && !rd_status);
      if (wr_ctrl) begin
        rx_ie <= bus_din[0];
        tx_ie <= bus_din[1];
      end
      if (wr_div) div_reg <= clamp_div(bus_din);
      if (rx_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (rx_push) wr_ptr <= wr_ptr + 1'b1;
      int_b <= !((rx_ie && !rxf_empty) || (tx_ie && !hold_full));
    end
  end

  logic [15:0] status;

  always_comb begin
    status                   = '0;
    status[ST_RX_AVAIL]      = !rxf_empty;
    status[ST_TX_HOLD_EMPTY] = !hold_full;
    status[ST_TX_BUSY]       = (tx_state != TX_IDLE);
    status[ST_RX_OVR]        = rx_ovr;
    status[ST_FRM_ERR]       = frm_err;
    status[ST_TX_OVR]        = tx_ovr;
  end

  always_comb begin
    bus_dout = '0;
    if (hit && rnw) begin
      unique case (ofs)
        OFS_DATA:   bus_dout = rxf_empty ? 16'h0000 : {8'h00, rx_head};
        OFS_STATUS: bus_dout = status;
        OFS_CTRL:   bus_dout = {14'h0000, tx_ie, rx_ie};
        OFS_DIV:    bus_dout = div_reg;
        default:    bus_dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_opc6_uart_io.sv
// Bench for opc6_uart_io: a frame-level model predicts txd every cycle and
// register reads; directed literals pin the key spec scenarios.
module tb_opc6_uart_io;

  logic        clk = 1'b0;
  logic        reset_b, clken, vio, rnw, rxd;
  logic [15:0] address, bus_din, bus_dout;
  logic        sel, txd, int_b;

  opc6_uart_io #(
    .BASE_ADDR (16'hFE00),
    .DIV_RESET (16'd434),
    .RXF_DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset_b  (reset_b),
    .clken    (clken),
    .vio      (vio),
    .rnw      (rnw),
    .address  (address),
    .bus_din  (bus_din),
    .bus_dout (bus_dout),
    .sel      (sel),
    .rxd      (rxd),
    .txd      (txd),
    .int_b    (int_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: each accepted TX byte becomes a frame with a known start edge.
  typedef struct {
    int         w;
    int         s;
    int         d;
    logic [7:0] data;
  } frame_t;

  frame_t     frames[$];
  logic [7:0] rx_q[$];
  int         m_div;
  logic       m_tx_ovr, m_rx_ovr, m_frm_err, m_rx_ie, m_tx_ie;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_txd(input int k);
    int idx;
    foreach (frames[i]) begin
      if (k >= frames[i].s && k < frames[i].s + 10 * frames[i].d) begin
        idx = (k - frames[i].s) / frames[i].d;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return frames[i].data[idx-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int k);
    foreach (frames[i])
      if (k >= frames[i].s && k < frames[i].s + 10 * frames[i].d) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_hold_full(input int k);
    if (frames.size() == 0) return 1'b0;
    return (frames[$].w <= k) && (k < frames[$].s);
  endfunction

  function automatic logic [15:0] exp_status(input int k);
    return {10'd0, m_tx_ovr, m_frm_err, m_rx_ovr, exp_busy(k), !exp_hold_full(k), rx_q.size() > 0};
  endfunction

  function automatic logic exp_int(input int k);
    return !((m_rx_ie && rx_q.size() > 0) || (m_tx_ie && !exp_hold_full(k)));
  endfunction

  task automatic model_reset();
    frames.delete();
    rx_q.delete();
    m_div     = 434;
    m_tx_ovr  = 1'b0;
    m_rx_ovr  = 1'b0;
    m_frm_err = 1'b0;
    m_rx_ie   = 1'b0;
    m_tx_ie   = 1'b0;
  endtask

  task automatic model_write(input logic [1:0] ofs, input logic [15:0] d, input int w);
    frame_t f;
    case (ofs)
      2'd0: begin
        if (frames.size() == 0 || w >= frames[$].s) begin
          f.w = w; f.s = w + 1; f.d = m_div; f.data = d[7:0];
          if (frames.size() > 0 && frames[$].s + 10 * frames[$].d > f.s)
            f.s = frames[$].s + 10 * frames[$].d;
          frames.push_back(f);
        end else begin
          m_tx_ovr = 1'b1;
        end
      end
      2'd2: begin m_rx_ie = d[0]; m_tx_ie = d[1]; end
      2'd3: m_div = (d < 16'd2) ? 2 : int'(d);
      default: ;
    endcase
  endtask

  // Bus tasks start just after a falling edge and return just after the next one.
  task automatic bus_write(input logic [1:0] ofs, input logic [15:0] d);
    vio = 1'b1; rnw = 1'b0; clken = 1'b1; address = 16'hFE00 | {14'd0, ofs}; bus_din = d;
    @(posedge clk); #1;
    model_write(ofs, d, cyc);
    @(negedge clk);
    vio = 1'b0; clken = 1'b0; rnw = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] ofs, input string name, output logic [15:0] data);
    logic [15:0] exp;
    vio = 1'b1; rnw = 1'b1; clken = 1'b1; address = 16'hFE00 | {14'd0, ofs};
    #1;
    data = bus_dout;
    case (ofs)
      2'd0:    exp = (rx_q.size() > 0) ? {8'h00, rx_q[0]} : 16'h0000;
      2'd1:    exp = exp_status(cyc);
      2'd2:    exp = {14'd0, m_tx_ie, m_rx_ie};
      default: exp = m_div[15:0];
    endcase
    check(name, data, exp);
    @(posedge clk); #1;
    if (ofs == 2'd0 && rx_q.size() > 0) void'(rx_q.pop_front());
    if (ofs == 2'd1) begin m_tx_ovr = 1'b0; m_rx_ovr = 1'b0; m_frm_err = 1'b0; end
    @(negedge clk);
    vio = 1'b0; clken = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      repeat (d) @(negedge clk);
    end
    rxd = 1'b1;
    if (!stop)                m_frm_err = 1'b1;
    else if (rx_q.size() < 4) rx_q.push_back(b);
    else                      m_rx_ovr = 1'b1;
  endtask

  // Per-cycle compare against the model, offset from the falling edge.
  always begin
    @(negedge clk);
    #2;
    check("txd", txd, exp_txd(cyc));
    check("sel", sel, vio && (address[15:2] == 14'h3F80));
    if (!sel) check("dout_unsel", bus_dout, 16'h0000);
  end

  logic [15:0] rd;
  logic [9:0]  a5_bits;
  int          w1;

  initial begin
    model_reset();
    reset_b = 1'b0; clken = 1'b0; vio = 1'b0; rnw = 1'b1;
    address = 16'h0000; bus_din = 16'h0000; rxd = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_int_b", int_b, 1'b1);
    check("rst_dout", bus_dout, 16'h0000);
    check("rst_sel", sel, 1'b0);
    reset_b = 1'b1;
    @(negedge clk);

    bus_read(2'd3, "div_reset", rd);   check("div_reset_lit", rd, 16'd434);
    bus_read(2'd1, "status_reset", rd); check("status_reset_lit", rd, 16'h0002);
    bus_read(2'd2, "ctrl_reset", rd);   check("ctrl_reset_lit", rd, 16'h0000);

    // TX of 0xA5 at DIV=4
    bus_write(2'd3, 16'd4);
    bus_write(2'd0, 16'h00A5);
    a5_bits = 10'b1_1010_0101_0;
    @(negedge clk);
    check("a5_bit0", txd, a5_bits[0]);
    for (int i = 1; i < 10; i++) begin
      repeat (4) @(negedge clk);
      check($sformatf("a5_bit%0d", i), txd, a5_bits[i]);
    end
    bus_read(2'd1, "status_tx_busy", rd);
    check("tx_busy_lit", rd & 16'h0004, 16'h0004);
    repeat (10) @(negedge clk);
    bus_read(2'd1, "status_tx_done", rd); check("tx_done_lit", rd, 16'h0002);

    // RX of 0x3C with rx_ie
    bus_write(2'd2, 16'h0001);
    send_rx(8'h3C, 1'b1, 4);
    repeat (10) @(negedge clk);
    check("int_rx", int_b, exp_int(cyc));
    check("int_rx_lit", int_b, 1'b0);
    bus_read(2'd1, "status_rx", rd); check("status_rx_lit", rd, 16'h0003);
    bus_read(2'd0, "data_3c", rd);   check("data_3c_lit", rd, 16'h003C);
    @(negedge clk);
    check("int_clear", int_b, exp_int(cyc));
    check("int_clear_lit", int_b, 1'b1);
    bus_read(2'd1, "status_rx_empty", rd); check("status_rx_empty_lit", rd, 16'h0002);

    // Five back-to-back bytes into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1, 4);
    repeat (10) @(negedge clk);
    bus_read(2'd1, "status_ovr1", rd); check("status_ovr1_lit", rd, 16'h000B);
    bus_read(2'd1, "status_ovr2", rd); check("status_ovr2_lit", rd, 16'h0003);
    for (int i = 1; i <= 4; i++) begin
      bus_read(2'd0, "fifo_data", rd);
      check($sformatf("fifo_data%0d_lit", i), rd, 16'(i));
    end
    bus_read(2'd0, "fifo_empty_read", rd); check("fifo_empty_read_lit", rd, 16'h0000);

    // Framing error, then a single-cycle glitch
    send_rx(8'h55, 1'b0, 4);
    repeat (10) @(negedge clk);
    bus_read(2'd1, "status_frm", rd);   check("status_frm_lit", rd, 16'h0012);
    bus_read(2'd1, "status_frm2", rd);  check("status_frm2_lit", rd, 16'h0002);
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    bus_read(2'd1, "status_glitch", rd); check("status_glitch_lit", rd, 16'h0002);

    // Two back-to-back writes plus one into a full holding register
    bus_write(2'd0, 16'h0011);
    w1 = cyc;
    bus_write(2'd0, 16'h0022);
    bus_write(2'd0, 16'h0033);
    bus_read(2'd1, "status_tx_ovr", rd); check("status_tx_ovr_lit", rd, 16'h0024);
    repeat (w1 + 40 - cyc) @(negedge clk);
    check("gap_stop_lit", txd, 1'b1);
    @(negedge clk);
    check("gap_start_lit", txd, 1'b0);
    repeat (60) @(negedge clk);
    bus_read(2'd1, "status_b2b_done", rd); check("status_b2b_done_lit", rd, 16'h0002);

    // Reset in the middle of a frame
    bus_write(2'd0, 16'h000F);
    repeat (10) @(negedge clk);
    reset_b = 1'b0;
    model_reset();
    #1;
    check("mid_reset_txd_lit", txd, 1'b1);
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    bus_read(2'd1, "status_after_rst", rd); check("status_after_rst_lit", rd, 16'h0002);
    bus_read(2'd3, "div_after_rst", rd);    check("div_after_rst_lit", rd, 16'd434);
    bus_write(2'd3, 16'd1);
    bus_read(2'd3, "div_clamp", rd);        check("div_clamp_lit", rd, 16'd2);
    bus_read(2'd2, "ctrl_after_rst", rd);   check("ctrl_after_rst_lit", rd, 16'h0000);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
